// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t       : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   DEFAULT_WIDTH : default operand width
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder.sv
// 1-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock,
// through a single 1-bit full adder.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request an addition (sampled only in IDLE)
//   a, b, cin     : operands, captured when start is accepted
//   busy          : high while in SHIFT or DONE
//   done          : one-cycle pulse when sum/cout/overflow are valid
//   sum, cout     : result, held until the next accepted start
//   overflow      : two's-complement overflow (carry into MSB ^ carry out)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  FullAdder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: carry holds the carry into the MSB.
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
            state    <= DONE;
          end
        end
        DONE: begin
          // done is registered, so it shows in the first IDLE cycle,
          // where a new start can already be accepted.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed literal cases,
// start-ignored and mid-operation reset cases, continuous start, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // m_t = clocks since acceptance (-1 when no operation is in flight).
  // busy for m_t in [0,W], done at m_t == W+1, result valid from m_t == W.
  int           m_t = -1;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ov = 1'b0;
  logic [W-1:0] p_a, p_b;
  logic         p_c;
  bit           check_en = 1'b0;

  always @(posedge clk) begin
    int tot, stot;
    if (rst) begin
      m_t <= -1; m_sum <= '0; m_cout <= 1'b0; m_ov <= 1'b0;
    end else if (m_t == -1 || m_t == W + 1) begin
      if (start) begin
        m_t <= 0; m_sum <= '0; m_cout <= 1'b0; m_ov <= 1'b0;
        p_a <= a; p_b <= b; p_c <= cin;
      end else begin
        m_t <= -1;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == W) begin
        tot  = int'(p_a) + int'(p_b) + int'(p_c);
        stot = int'($signed(p_a)) + int'($signed(p_b)) + int'(p_c);
        m_sum  <= tot[W-1:0];
        m_cout <= tot[W];
        m_ov   <= (stot > (2**(W-1)) - 1) || (stot < -(2**(W-1)));
      end
    end
  end

  // ---------------- compare process ----------------
  bit hold_mode = 1'b0;
  bit prev_hold = 1'b0;
  int cyc = 0;
  int last_done = -1;

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      chk("busy", 32'(busy), 32'(m_t >= 0 && m_t <= W));
      chk("done", 32'(done), 32'(m_t == W + 1));
      if (m_t == -1 || m_t == 0 || m_t >= W) begin
        chk("sum", 32'(sum), 32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("overflow", 32'(overflow), 32'(m_ov));
      end
    end
    if (hold_mode && !prev_hold) last_done = -1;
    prev_hold = hold_mode;
    if (hold_mode && done === 1'b1) begin
      if (last_done >= 0) chk("done_interval", 32'(cyc - last_done), 32'd10);
      last_done = cyc;
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2ns after a rising edge; the DUT samples at the next one.
  task automatic drive_cycle();
    @(posedge clk);
    #2;
  endtask

  // Single operation with literal expectations; begins with the DUT idle.
  task automatic run_lit(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic [W-1:0] es,
                         input logic ec, input logic eo, input string tag);
    start = 1'b1; a = va; b = vb; cin = vc;
    drive_cycle();                      // acceptance edge k
    start = 1'b0; a = $urandom; b = $urandom;
    repeat (W) drive_cycle();           // now just after edge k+W
    @(negedge clk);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    drive_cycle();                      // edge k+W+1
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ov"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) drive_cycle();
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    drive_cycle();

    // Directed literal cases
    run_lit(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "lit5a3c");
    run_lit(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "litff01");
    run_lit(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "litffff");
    run_lit(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "lit7f_c");

    // start pulsed with new operands 3 cycles into SHIFT is ignored
    drive_cycle();
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    drive_cycle();                      // edge k
    start = 1'b0;
    repeat (3) drive_cycle();
    start = 1'b1; a = 8'hEE; b = 8'hDD; cin = 1'b0;
    drive_cycle();
    start = 1'b0;
    repeat (W - 4) drive_cycle();       // just after edge k+W
    @(negedge clk);
    chk("ign_done_early", 32'(done), 32'd0);
    drive_cycle();
    @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum", 32'(sum), 32'h47);
    chk("ign_cout", 32'(cout), 32'd0);

    // Reset during the 4th SHIFT cycle
    drive_cycle();
    start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    drive_cycle();                      // edge k
    start = 1'b0;
    repeat (3) drive_cycle();           // in the 4th SHIFT cycle
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out", 32'({cout, overflow, sum}), 32'd0);
    drive_cycle();
    run_lit(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "post_rst");

    // start held high with changing operands
    hold_mode = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 55; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom);
      drive_cycle();
    end
    start = 1'b0;
    hold_mode = 1'b0;
    repeat (W + 3) drive_cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = $urandom; b = $urandom; cin = 1'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      drive_cycle();
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 3) drive_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high in SHIFT and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, WIDTH bits: the result.
REQ-011 SHALL have port cout, output, 1 bit: the final carry-out.
REQ-012 SHALL have port overflow, output, 1 bit: two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.

Function
REQ-013 SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, using exactly one 1-bit full-adder instance.
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
- IDLE -> SHIFT when start=1.
- SHIFT -> DONE after WIDTH cycles in SHIFT.
- DONE -> IDLE unconditionally.
REQ-015 SHALL, on accepting start (IDLE and start=1 at edge k), load the operand shift registers, load the carry register with cin, clear the bit counter, and clear sum, cout and overflow.
REQ-016 SHALL, in each SHIFT cycle, feed the current LSBs of A and B plus the carry register into the adder, shift the sum bit into sum from the MSB side, register the carry-out, and increment the counter.
REQ-017 SHALL assert done, with sum, cout and overflow valid, in the cycle after edge k+WIDTH+1, giving a fixed latency of WIDTH+1 clocks from acceptance.
REQ-018 SHALL hold sum, cout and overflow stable from done until the next start is accepted.
REQ-019 SHALL ignore start while in SHIFT or DONE; an operand change during SHIFT SHALL NOT affect the result.
REQ-020 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back operations every WIDTH+2 cycles.
REQ-021 SHALL use a bit counter of $clog2(WIDTH+1) bits and SHALL NOT wrap within an operation.

Reset
REQ-022 SHALL, on rst=1 at any clock edge (including mid-SHIFT), enter IDLE and drive busy=0, done=0, sum=0, cout=0, overflow=0, and clear the counter and carry register.
REQ-023 SHALL give rst priority over start in the same cycle.

Structure
REQ-024 SHALL place the state encoding (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH constant in a shared package, serial_add_pkg.
REQ-025 SHALL instantiate the team's existing 1-bit FullAdder cell as its single sub-module; there SHALL be no other arithmetic operators on the datapath.

Verification
REQ-026 SHALL cover, at WIDTH=8: a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, overflow=1, with done exactly 9 clocks after acceptance.
REQ-027 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0.
REQ-028 SHALL cover: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0.
REQ-029 SHALL cover: start pulsed with new operands 3 cycles into SHIFT -> ignored; the original result returns with unchanged timing.
REQ-030 SHALL cover: rst asserted during the 4th SHIFT cycle -> next cycle busy=0, done=0, all outputs 0; a fresh start then completes correctly.
REQ-031 SHALL cover: start held high continuously -> done pulses every 10 clocks, and each result matches its captured operands.
